// File: rtl/fft_pkg.sv
// Shared constants, twiddle values and fill-state type for the DSP48-based radix-2 FFT.
package fft_pkg;

    localparam int DATA_W       = 18;
    localparam int TW_FRAC      = 14;
    localparam int BFLY_LATENCY = 3;

    typedef struct packed {
        logic signed [DATA_W-1:0] re;
        logic signed [DATA_W-1:0] im;
    } twiddle_t;

    localparam logic signed [DATA_W-1:0] W_ONE   = 18'sd16384;
    localparam twiddle_t                 W_NEG_J = '{re: 18'sd0, im: -18'sd16384};

    // Fill progress of the butterfly pipeline; FILL_FULL means results are valid.
    typedef enum logic [1:0] {
        FILL_0,
        FILL_1,
        FILL_2,
        FILL_FULL
    } fill_e;

    function automatic fill_e fill_advance(input fill_e cur);
        case (cur)
            FILL_0:  return FILL_1;
            FILL_1:  return FILL_2;
            default: return FILL_FULL;
        endcase
    endfunction

endpackage

// File: rtl/butterfly_2_cmult_q.sv
// Registered complex multiply by a fixed-point twiddle (S1 inputs, S2 partial products),
// then scale by TW_FRAC to N+1 bits. ROUND_EN defined: round half toward +inf; else floor.
module cmult_q #(
    parameter int N       = fft_pkg::DATA_W,
    parameter int TW_FRAC = fft_pkg::TW_FRAC
) (
    input  logic                clk,
    input  logic                rst,
    input  logic signed [N-1:0] a_r,
    input  logic signed [N-1:0] a_i,
    input  logic signed [N-1:0] w_r,
    input  logic signed [N-1:0] w_i,
    output logic signed [N:0]   p_r,
    output logic signed [N:0]   p_i
);

    localparam int MW = 2 * N;
    localparam int PW = 2 * N + 1;
    localparam int OW = N + 1;

`ifdef ROUND_EN
    localparam logic signed [PW-1:0] BIAS = {{(PW-1){1'b0}}, 1'b1} << (TW_FRAC - 1);
`else
    localparam logic signed [PW-1:0] BIAS = '0;
`endif

    logic signed [N-1:0]  a_r_q, a_i_q, w_r_q, w_i_q;
    logic signed [MW-1:0] m_rr, m_ii, m_ri, m_ir;
    logic signed [PW-1:0] sum_r, sum_i;

    // NOTE: pipeline registers use non-blocking assignments so S2 multiplies the S1 values
    // captured on the previous edge, independent of statement order.
    // NOTE: every pipeline register is reset, so the outputs read zero the moment rst falls.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_r_q <= '0;
            a_i_q <= '0;
            w_r_q <= '0;
            w_i_q <= '0;
            m_rr  <= '0;
            m_ii  <= '0;
            m_ri  <= '0;
            m_ir  <= '0;
        end else begin
            a_r_q <= a_r;
            a_i_q <= a_i;
            w_r_q <= w_r;
            w_i_q <= w_i;
            m_rr  <= MW'(a_r_q) * MW'(w_r_q);
            m_ii  <= MW'(a_i_q) * MW'(w_i_q);
            m_ri  <= MW'(a_r_q) * MW'(w_i_q);
            m_ir  <= MW'(a_i_q) * MW'(w_r_q);
        end
    end

    assign sum_r = PW'(m_rr) - PW'(m_ii) + BIAS;
    assign sum_i = PW'(m_ri) + PW'(m_ir) + BIAS;

    // Arithmetic shift floors toward -inf; the cast then wraps to N+1 bits.
    assign p_r = OW'(sum_r >>> TW_FRAC);
    assign p_i = OW'(sum_i >>> TW_FRAC);

endmodule

// File: rtl/butterfly_2.sv
// Radix-2 DIT butterfly: out0 = in0 + W*in1, out1 = in0 - W*in1, 3-cycle latency.
// Optional ROUND_EN macro selects rounded twiddle scaling inside cmult_q.
module butterfly_2
    import fft_pkg::*;
#(
    parameter int N       = DATA_W,
    parameter int TW_FRAC = fft_pkg::TW_FRAC
) (
    input  logic                clk,
    input  logic                rst,
    input  logic signed [N-1:0] in0_r,
    input  logic signed [N-1:0] in0_i,
    input  logic signed [N-1:0] in1_r,
    input  logic signed [N-1:0] in1_i,
    input  logic signed [N-1:0] twiddle_r,
    input  logic signed [N-1:0] twiddle_i,
    input  logic                start,
    output logic signed [N:0]   f2out0_r,
    output logic signed [N:0]   f2out0_i,
    output logic signed [N:0]   f2out1_r,
    output logic signed [N:0]   f2out1_i,
    output logic                done
);

    logic signed [N-1:0] in0_r_q, in0_i_q, in0_r_d, in0_i_d;
    logic signed [N:0]   in0_r_x, in0_i_x;
    logic signed [N:0]   p_r, p_i;
    fill_e               fill_q, fill_nxt;

    cmult_q #(
        .N       (N),
        .TW_FRAC (TW_FRAC)
    ) u_cmult (
        .clk (clk),
        .rst (rst),
        .a_r (in1_r),
        .a_i (in1_i),
        .w_r (twiddle_r),
        .w_i (twiddle_i),
        .p_r (p_r),
        .p_i (p_i)
    );

    // in0 rides two registers to meet the product at the add/sub stage.
    assign in0_r_x = {in0_r_d[N-1], in0_r_d};
    assign in0_i_x = {in0_i_d[N-1], in0_i_d};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in0_r_q  <= '0;
            in0_i_q  <= '0;
            in0_r_d  <= '0;
            in0_i_d  <= '0;
            f2out0_r <= '0;
            f2out0_i <= '0;
            f2out1_r <= '0;
            f2out1_i <= '0;
        end else begin
            in0_r_q  <= in0_r;
            in0_i_q  <= in0_i;
            in0_r_d  <= in0_r_q;
            in0_i_d  <= in0_i_q;
            f2out0_r <= in0_r_x + p_r;
            f2out0_i <= in0_i_x + p_i;
            f2out1_r <= in0_r_x - p_r;
            f2out1_i <= in0_i_x - p_i;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fill_q <= FILL_0;
        end else begin
            fill_q <= fill_nxt;
        end
    end

    // NOTE: defaults are assigned before any branch so no path leaves a signal unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        fill_nxt = FILL_0;
        done     = 1'b0;
        if (start) begin
            fill_nxt = fill_advance(fill_q);
        end
        if (fill_q == FILL_FULL) begin
            done = 1'b1;
        end
    end

endmodule

// File: tb/tb_butterfly_2.sv
// Directed self-checking bench for butterfly_2: arithmetic, rounding, corner, done timing and reset.
module tb_butterfly_2;
    import fft_pkg::*;

    localparam int N  = DATA_W;
    localparam int OW = N + 1;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic signed [N-1:0] in0_r = '0, in0_i = '0, in1_r = '0, in1_i = '0;
    logic signed [N-1:0] twiddle_r = '0, twiddle_i = '0;
    logic                start = 1'b0;
    logic signed [N:0]   f2out0_r, f2out0_i, f2out1_r, f2out1_i;
    logic                done;

    int n_tests = 0;
    int n_fail  = 0;

    // Streaming vectors with W = 1.0: {in0_r, in0_i, in1_r, in1_i} -> {out0_r, out0_i, out1_r, out1_i}
    int v_in  [5][4] = '{'{1, 2, 3, 4}, '{-5, 5, 7, -7}, '{1000, -1000, -1, 1},
                         '{131071, 0, 131071, 0}, '{0, -131072, 0, 131071}};
    int v_exp [5][4] = '{'{4, 6, -2, -2}, '{2, -2, -12, 12}, '{999, -999, 1001, -1001},
                         '{262142, 0, 0, 0}, '{0, -1, 0, -262143}};

    butterfly_2 dut (
        .clk       (clk),
        .rst       (rst),
        .in0_r     (in0_r),
        .in0_i     (in0_i),
        .in1_r     (in1_r),
        .in1_i     (in1_i),
        .twiddle_r (twiddle_r),
        .twiddle_i (twiddle_i),
        .start     (start),
        .f2out0_r  (f2out0_r),
        .f2out0_i  (f2out0_i),
        .f2out1_r  (f2out1_r),
        .f2out1_i  (f2out1_i),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic drive(input int a_r, input int a_i, input int b_r, input int b_i,
                         input int w_r, input int w_i);
        in0_r     = N'(a_r);
        in0_i     = N'(a_i);
        in1_r     = N'(b_r);
        in1_i     = N'(b_i);
        twiddle_r = N'(w_r);
        twiddle_i = N'(w_i);
    endtask

    task automatic test_reset();
        drive(100, 100, 100, 100, int'(W_ONE), 0);
        start = 1'b1;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({f2out0_r, f2out0_i, f2out1_r, f2out1_i, done} !== '0) begin
            n_fail++;
            $display("FAIL reset_hold: out0=(%0d,%0d) out1=(%0d,%0d) done=%b, expected all 0",
                     f2out0_r, f2out0_i, f2out1_r, f2out1_i, done);
        end
        start = 1'b0;
        rst   = 1'b1;
        @(negedge clk);
        n_tests++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle_done: done=%b, expected 0", done);
        end
    endtask

    task automatic test_identity();
        drive(100, -7, 50, 3, int'(W_ONE), 0);
        start = 1'b1;
        for (int e = 1; e <= BFLY_LATENCY; e++) begin
            @(negedge clk);
            n_tests++;
            if (done !== (e == BFLY_LATENCY)) begin
                n_fail++;
                $display("FAIL identity_done_edge%0d: done=%b, expected %b", e, done, e == BFLY_LATENCY);
            end
        end
        n_tests++;
        if (f2out0_r !== OW'(150) || f2out0_i !== OW'(-4) || f2out1_r !== OW'(50) || f2out1_i !== OW'(-10)) begin
            n_fail++;
            $display("FAIL identity_out: out0=(%0d,%0d) out1=(%0d,%0d), expected (150,-4) (50,-10)",
                     f2out0_r, f2out0_i, f2out1_r, f2out1_i);
        end
    endtask

    task automatic test_neg_j();
        @(negedge clk);
        drive(10, 20, 3, 4, int'(W_NEG_J.re), int'(W_NEG_J.im));
        repeat (BFLY_LATENCY) @(negedge clk);
        n_tests++;
        if (f2out0_r !== OW'(14) || f2out0_i !== OW'(17) || f2out1_r !== OW'(6) || f2out1_i !== OW'(23)
            || done !== 1'b1) begin
            n_fail++;
            $display("FAIL neg_j_out: out0=(%0d,%0d) out1=(%0d,%0d) done=%b, expected (14,17) (6,23) done=1",
                     f2out0_r, f2out0_i, f2out1_r, f2out1_i, done);
        end
    endtask

    task automatic test_rounding();
        int e0r, e0i, e1r, e1i;
`ifdef ROUND_EN
        e0r = -1; e0i = 2; e1r = 1; e1i = -2;
`else
        e0r = -2; e0i = 1; e1r = 2; e1i = -1;
`endif
        @(negedge clk);
        drive(0, 0, -3, 3, 8192, 0);
        repeat (BFLY_LATENCY) @(negedge clk);
        n_tests++;
        if (f2out0_r !== OW'(e0r) || f2out0_i !== OW'(e0i) || f2out1_r !== OW'(e1r) || f2out1_i !== OW'(e1i)) begin
            n_fail++;
            $display("FAIL half_scale_round: out0=(%0d,%0d) out1=(%0d,%0d), expected (%0d,%0d) (%0d,%0d)",
                     f2out0_r, f2out0_i, f2out1_r, f2out1_i, e0r, e0i, e1r, e1i);
        end
    endtask

    task automatic test_corner();
        @(negedge clk);
        drive(-131072, -131072, -131072, -131072, int'(W_ONE), 0);
        repeat (BFLY_LATENCY) @(negedge clk);
        n_tests++;
        if (f2out0_r !== OW'(-262144) || f2out0_i !== OW'(-262144) || f2out1_r !== OW'(0) || f2out1_i !== OW'(0)) begin
            n_fail++;
            $display("FAIL corner_min: out0=(%0d,%0d) out1=(%0d,%0d), expected (-262144,-262144) (0,0)",
                     f2out0_r, f2out0_i, f2out1_r, f2out1_i);
        end
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (n >= BFLY_LATENCY) begin
                int k;
                k = n - BFLY_LATENCY;
                n_tests++;
                if (f2out0_r !== OW'(v_exp[k][0]) || f2out0_i !== OW'(v_exp[k][1]) ||
                    f2out1_r !== OW'(v_exp[k][2]) || f2out1_i !== OW'(v_exp[k][3]) || done !== 1'b1) begin
                    n_fail++;
                    $display("FAIL stream_vec%0d: out0=(%0d,%0d) out1=(%0d,%0d) done=%b, expected (%0d,%0d) (%0d,%0d) done=1",
                             k, f2out0_r, f2out0_i, f2out1_r, f2out1_i, done,
                             v_exp[k][0], v_exp[k][1], v_exp[k][2], v_exp[k][3]);
                end
            end
            if (n < 5) begin
                drive(v_in[n][0], v_in[n][1], v_in[n][2], v_in[n][3], int'(W_ONE), 0);
            end
        end
    endtask

    task automatic test_start_drop();
        @(negedge clk);
        start = 1'b0;
        drive(100, -7, 50, 3, int'(W_ONE), 0);
        @(negedge clk);
        n_tests++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL drop_done_clear: done=%b, expected 0", done);
        end
        start = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_tests++;
        if (done !== 1'b0 || f2out0_r !== OW'(150) || f2out0_i !== OW'(-4) ||
            f2out1_r !== OW'(50) || f2out1_i !== OW'(-10)) begin
            n_fail++;
            $display("FAIL drop_streaming: out0=(%0d,%0d) out1=(%0d,%0d) done=%b, expected (150,-4) (50,-10) done=0",
                     f2out0_r, f2out0_i, f2out1_r, f2out1_i, done);
        end
        @(negedge clk);
        n_tests++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL drop_refill: done=%b, expected 1", done);
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        n_tests++;
        if ({f2out0_r, f2out0_i, f2out1_r, f2out1_i, done} !== '0) begin
            n_fail++;
            $display("FAIL async_reset: out0=(%0d,%0d) out1=(%0d,%0d) done=%b, expected all 0",
                     f2out0_r, f2out0_i, f2out1_r, f2out1_i, done);
        end
        @(negedge clk);
        #2 rst = 1'b1;
        for (int e = 1; e <= BFLY_LATENCY; e++) begin
            @(negedge clk);
            n_tests++;
            if (done !== (e == BFLY_LATENCY)) begin
                n_fail++;
                $display("FAIL post_reset_done_edge%0d: done=%b, expected %b", e, done, e == BFLY_LATENCY);
            end
        end
        n_tests++;
        if (f2out0_r !== OW'(150) || f2out0_i !== OW'(-4) || f2out1_r !== OW'(50) || f2out1_i !== OW'(-10)) begin
            n_fail++;
            $display("FAIL post_reset_out: out0=(%0d,%0d) out1=(%0d,%0d), expected (150,-4) (50,-10)",
                     f2out0_r, f2out0_i, f2out1_r, f2out1_i);
        end
    endtask

    initial begin
        test_reset();
        test_identity();
        test_neg_j();
        test_rounding();
        test_corner();
        test_back_to_back();
        test_start_drop();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
